// File: rtl/dma_scheduler_if.sv
// DMA controller handshake bundle: HDMA enable/busy status in, HDMA init/start pulses out.
// The master modport is the scheduler; the slave modport is the DMA controller.
interface dma_scheduler_if;
    logic hdma_any;
    logic dma_busy;
    logic hdma_init;
    logic hdma_start;

    modport master (
        input  hdma_any,
        input  dma_busy,
        output hdma_init,
        output hdma_start
    );

    modport slave (
        output hdma_any,
        output dma_busy,
        input  hdma_init,
        input  hdma_start
    );
endinterface

// File: rtl/dma_scheduler.sv
// DMA scheduler: HDMA init/start pulses from video timing and the CPU halt window around DMA.
// Optional per-frame halt statistics are enabled by defining DMA_SCHED_STATS_EN.
module dma_scheduler #(
    parameter logic [8:0] HINIT_DOT  = 9'd6,
    parameter logic [8:0] HSTART_DOT = 9'd278,
    parameter logic [8:0] VIS_LAST   = 9'd224,
    parameter logic [2:0] ALIGN      = 3'd0,
    parameter logic [3:0] RESUME_CYC = 4'd8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_en,
    input  logic [8:0]             hcount,
    input  logic [8:0]             vcount,
    input  logic                   overscan,
    dma_scheduler_if.master        bus,
    output logic                   cpu_halt,
    output logic [2:0]             phase
`ifdef DMA_SCHED_STATS_EN
    ,
    output logic [15:0]            halt_cycles,
    output logic [15:0]            last_frame_halt
`endif
);

    typedef enum logic [1:0] {
        RUN,
        ALIGN_W,
        HALT,
        RESUME
    } state_t;

    state_t     state;
    logic       init_latch;
    logic       start_latch;
    logic       pending;
    logic [3:0] resume_cnt;

    logic       in_visible;
    logic       init_fire;
    logic       start_fire;
    logic       pulse;
    logic       request;

    // Overscan pushes the last visible line down by one.
    assign in_visible = {1'b0, vcount} <= ({1'b0, VIS_LAST} + 10'(overscan));

    assign init_fire  = (vcount == 9'd0) && (hcount == HINIT_DOT) && bus.hdma_any && !init_latch;
    assign start_fire = (hcount == HSTART_DOT) && in_visible && bus.hdma_any && !start_latch;

    // A pulse already on its way to the DMA controller counts as DMA activity.
    assign pulse   = bus.hdma_init | bus.hdma_start;
    assign request = bus.dma_busy | pulse;

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch sees the values from before this edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase          <= 3'd0;
            bus.hdma_init  <= 1'b0;
            bus.hdma_start <= 1'b0;
            init_latch     <= 1'b0;
            start_latch    <= 1'b0;
            pending        <= 1'b0;
            resume_cnt     <= 4'd0;
            cpu_halt       <= 1'b0;
            state          <= RUN;
        end else begin
            phase          <= phase + 3'd1;
            bus.hdma_init  <= init_fire;
            bus.hdma_start <= start_fire;

            if (vcount != 9'd0)
                init_latch <= 1'b0;
            else if (init_fire)
                init_latch <= 1'b1;

            if (hcount != HSTART_DOT)
                start_latch <= 1'b0;
            else if (start_fire)
                start_latch <= 1'b1;

            case (state)
                RUN: begin
                    // Halt may only begin on a CPU cycle boundary; otherwise remember the request.
                    if ((request || pending) && cpu_en) begin
                        state    <= ALIGN_W;
                        cpu_halt <= 1'b1;
                        pending  <= 1'b0;
                    end else if (request) begin
                        pending  <= 1'b1;
                    end
                end
                ALIGN_W: begin
                    if (phase == ALIGN)
                        state <= HALT;
                end
                HALT: begin
                    if (!request) begin
                        resume_cnt <= RESUME_CYC - 4'd1;
                        state      <= RESUME;
                    end
                end
                RESUME: begin
                    // Re-entry from RESUME skips alignment: the CPU is already stopped.
                    if (request) begin
                        state <= HALT;
                    end else if (resume_cnt == 4'd0) begin
                        state    <= RUN;
                        cpu_halt <= 1'b0;
                    end else begin
                        resume_cnt <= resume_cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= RUN;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMA_SCHED_STATS_EN
    logic frame_origin;
    logic frame_origin_q;

    assign frame_origin = (vcount == 9'd0) && (hcount == 9'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            halt_cycles     <= 16'd0;
            last_frame_halt <= 16'd0;
            frame_origin_q  <= 1'b0;
        end else begin
            frame_origin_q <= frame_origin;
            // Only the first clk at the frame origin closes the frame, even if the dot stalls there.
            if (frame_origin && !frame_origin_q) begin
                last_frame_halt <= halt_cycles;
                halt_cycles     <= 16'd0;
            end else if (cpu_halt && (halt_cycles != 16'hFFFF)) begin
                halt_cycles <= halt_cycles + 16'd1;
            end
        end
    end
`endif

endmodule
